// File: rtl/mult_seq_ctrl.sv
// Sequencer and 9-bit add/subtract stage for the 8x8 signed add-shift multiplier.
// Drives load/clear/shift strobes for the external A and B shift registers
// and owns the extension bit X that feeds A's serial input.
module mult_seq_ctrl (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_run,
    input  logic                  i_clear_a_load_b,
    input  logic                  i_m,
    input  logic [7:0]            i_a,
    input  logic [7:0]            i_s,
    output logic [7:0]            o_sum_c,
    output logic                  o_ld_a_c,
    output logic                  o_clr_a_c,
    output logic                  o_ld_b_c,
    output logic                  o_shift,
    output logic                  o_x,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_x;
    logic               w_x_nxt;
    logic               r_shift;
    logic               r_busy;
    logic               r_done;

    logic               w_sub;
    logic [W:0]         w_a9;
    logic [W:0]         w_s9;
    logic [W:0]         w_sum9;

    // Sign-extended add; the last digit carries negative weight, so subtract there
    assign w_sub   = (r_cnt == CNT_LAST);
    assign w_a9    = {i_a[W-1], i_a};
    assign w_s9    = {i_s[W-1], i_s};
    assign w_sum9  = w_a9 + (w_sub ? ~w_s9 : w_s9) + (W+1)'(w_sub);
    assign o_sum_c = w_sum9[W-1:0];

    assign o_x     = r_x;
    assign o_shift = r_shift;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    // State, counter, X and registered status decodes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_shift <= (w_state_nxt == S_SHIFT);
            r_busy  <= (w_state_nxt == S_CLR) || (w_state_nxt == S_ADD) ||
                       (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_HOLD);
        end
    end

    // Next-state logic and register-file strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        o_ld_a_c    = 1'b0;
        o_clr_a_c   = 1'b0;
        o_ld_b_c    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_nxt = S_CLR;
                end else if (i_clear_a_load_b) begin
                    o_clr_a_c = 1'b1;
                    o_ld_b_c  = 1'b1;
                    w_x_nxt   = 1'b0;
                end
            end
            S_CLR: begin
                o_clr_a_c   = 1'b1;
                w_x_nxt     = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                if (i_m) begin
                    o_ld_a_c = 1'b1;
                    w_x_nxt  = w_sum9[W];
                end
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = S_ADD;
                end
            end
            S_HOLD: begin
                if (!i_run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
